// File: rtl/decodificador_teclado.sv
// decodificador_teclado
//   Keypad front end for the door lock. Scans a 4x3 active-low matrix keypad,
//   debounces each press and release, maps the key to a 4-bit code and shifts
//   it into a 20-digit packet handed to the operational controller.
//
// Ports
//   clk           : single clock, rising edge
//   rst           : synchronous reset, active high
//   teclado_en    : keypad enable; low clears the packet and parks the scanner
//   lin[3:0]      : row inputs, active low (pulled up)
//   col[2:0]      : column drives, active low, at most one low at a time
//   digitos_value : packet, 20 nibbles; [3:0] is the newest key, 0xF = empty
//   digitos_valid : one-cycle pulse when digitos_value just took a new key
module decodificador_teclado #(
  parameter int SCAN_CYCLES     = 10,
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int TIMEOUT_CYCLES  = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        teclado_en,
  input  logic [3:0]  lin,
  output logic [2:0]  col,
  output logic [79:0] digitos_value,
  output logic        digitos_valid
);

  typedef enum logic [2:0] {
    SCAN     = 3'd0,
    DEBOUNCE = 3'd1,
    EMIT     = 3'd2,
    CLEAR    = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [79:0]      ALL_EMPTY = {20{4'hF}};
  localparam logic [2:0]       COL_OFF   = 3'b111;

  state_t           state_p0, state_nx;
  logic [1:0]       idx_p0, idx_nx;
  logic [CNT_W-1:0] cnt_p0, cnt_nx;
  logic [TO_W-1:0]  idle_p0, idle_nx;
  logic [2:0]       col_p0, col_nx;
  logic [79:0]      digits_p0, digits_nx;
  logic             vld_p0, vld_nx;
  logic [3:0]       pat_p0, pat_nx;
  logic [3:0]       code;

  function automatic logic [2:0] col_drive(input logic [1:0] c);
    case (c)
      2'd0:    col_drive = 3'b110;
      2'd1:    col_drive = 3'b101;
      default: col_drive = 3'b011;
    endcase
  endfunction

  function automatic logic [1:0] next_idx(input logic [1:0] c);
    next_idx = (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  // Exactly one row pulled low; simultaneous presses in a column are ignored.
  function automatic logic single_low(input logic [3:0] rows);
    case (rows)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
      default:                            single_low = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] key_code(input logic [3:0] rows, input logic [1:0] c);
    logic [1:0] r;
    case (rows)
      4'b1110: r = 2'd0;
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      default: r = 2'd3;
    endcase
    case ({r, c})
      4'b00_00: key_code = 4'h1;
      4'b00_01: key_code = 4'h2;
      4'b00_10: key_code = 4'h3;
      4'b01_00: key_code = 4'h4;
      4'b01_01: key_code = 4'h5;
      4'b01_10: key_code = 4'h6;
      4'b10_00: key_code = 4'h7;
      4'b10_01: key_code = 4'h8;
      4'b10_10: key_code = 4'h9;
      4'b11_00: key_code = 4'hA;
      4'b11_01: key_code = 4'h0;
      default:  key_code = 4'hB;
    endcase
  endfunction

  assign code = key_code(pat_p0, idx_p0);

  always_comb begin
    state_nx  = state_p0;
    idx_nx    = idx_p0;
    cnt_nx    = cnt_p0;
    idle_nx   = idle_p0;
    col_nx    = col_p0;
    digits_nx = digits_p0;
    vld_nx    = 1'b0;
    pat_nx    = pat_p0;

    if (!teclado_en) begin
      state_nx  = SCAN;
      idx_nx    = 2'd0;
      cnt_nx    = '0;
      idle_nx   = '0;
      col_nx    = COL_OFF;
      digits_nx = ALL_EMPTY;
    end else begin
      case (state_p0)
        SCAN: begin
          // All columns released means the scanner is parked: start driving
          // the current column and begin its settle count on the next cycle.
          if (col_p0 == COL_OFF) begin
            col_nx = col_drive(idx_p0);
            cnt_nx = '0;
          end else if (cnt_p0 == SCAN_LAST) begin
            cnt_nx = '0;
            if (single_low(lin)) begin
              pat_nx   = lin;
              state_nx = DEBOUNCE;
            end else begin
              idx_nx = next_idx(idx_p0);
              col_nx = col_drive(next_idx(idx_p0));
            end
          end else begin
            cnt_nx = cnt_p0 + 1'b1;
          end

          if (digits_p0 == ALL_EMPTY) begin
            idle_nx = '0;
          end else if (idle_p0 == TO_LAST) begin
            idle_nx   = '0;
            digits_nx = ALL_EMPTY;
          end else begin
            idle_nx = idle_p0 + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (lin != pat_p0) begin
            state_nx = SCAN;
            cnt_nx   = '0;
          end else if (cnt_p0 == DEB_LAST) begin
            state_nx = EMIT;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt_p0 + 1'b1;
          end
        end

        EMIT: begin
          digits_nx = {digits_p0[75:0], code};
          vld_nx    = 1'b1;
          idle_nx   = '0;
          cnt_nx    = '0;
          state_nx  = (code == 4'hA || code == 4'hB) ? CLEAR : RELEASE;
        end

        CLEAR: begin
          digits_nx = ALL_EMPTY;
          state_nx  = RELEASE;
        end

        RELEASE: begin
          if (lin != 4'b1111) begin
            cnt_nx = '0;
          end else if (cnt_p0 == DEB_LAST) begin
            // Park the columns for one cycle before driving the next one,
            // so consecutive accepted keys are always separated by that gap.
            cnt_nx   = '0;
            state_nx = SCAN;
            idx_nx   = next_idx(idx_p0);
            col_nx   = COL_OFF;
          end else begin
            cnt_nx = cnt_p0 + 1'b1;
          end
        end

        default: begin
          state_nx = SCAN;
          idx_nx   = 2'd0;
          cnt_nx   = '0;
          col_nx   = COL_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0  <= SCAN;
      idx_p0    <= 2'd0;
      cnt_p0    <= '0;
      idle_p0   <= '0;
      col_p0    <= COL_OFF;
      digits_p0 <= ALL_EMPTY;
      vld_p0    <= 1'b0;
    end else begin
      state_p0  <= state_nx;
      idx_p0    <= idx_nx;
      cnt_p0    <= cnt_nx;
      idle_p0   <= idle_nx;
      col_p0    <= col_nx;
      digits_p0 <= digits_nx;
      vld_p0    <= vld_nx;
    end
  end

  always_ff @(posedge clk) begin
    pat_p0 <= pat_nx;
  end

  assign col           = col_p0;
  assign digitos_value = digits_p0;
  assign digitos_valid = vld_p0;

endmodule

// File: tb/tb_decodificador_teclado.sv
// Testbench for decodificador_teclado: keypad matrix model, expected-key
// queue with a packet model checked every cycle, and directed scenarios.
module tb_decodificador_teclado;

  localparam int SCAN_CYCLES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int TIMEOUT_CYCLES  = 60;
  localparam logic [79:0] ALL_F  = {20{4'hF}};

  logic        clk = 1'b0;
  logic        rst;
  logic        teclado_en;
  logic [3:0]  lin;
  logic [2:0]  col;
  logic [79:0] digitos_value;
  logic        digitos_valid;

  logic [2:0]  pressed [4];
  logic [3:0]  exp_q [$];
  logic [79:0] model_buf;
  logic [3:0]  chk_code;
  logic [79:0] chk_exp;
  bit          chk_on = 1'b0;
  bit          allow_clear = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pulses = 0;

  always #5 clk = ~clk;

  decodificador_teclado #(
    .SCAN_CYCLES     (SCAN_CYCLES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .teclado_en    (teclado_en),
    .lin           (lin),
    .col           (col),
    .digitos_value (digitos_value),
    .digitos_valid (digitos_valid)
  );

  // Row r is pulled low when any pressed key of that row sits on a driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) lin[r] = ~|(pressed[r] & ~col);
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, act, expv);
    end
  endtask

  // Returns {row, col} of a key code.
  function automatic logic [3:0] key_pos(input logic [3:0] code);
    int r, c;
    if (code >= 4'd1 && code <= 4'd9) begin
      r = (int'(code) - 1) / 3;
      c = (int'(code) - 1) % 3;
    end else if (code == 4'h0) begin
      r = 3; c = 1;
    end else if (code == 4'hA) begin
      r = 3; c = 0;
    end else begin
      r = 3; c = 2;
    end
    key_pos = {2'(r), 2'(c)};
  endfunction

  task automatic set_key(input logic [3:0] code, input logic v);
    logic [3:0] rc;
    rc = key_pos(code);
    pressed[rc[3:2]][rc[1:0]] = v;
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int gap, input bit expect_pulse);
    set_key(code, 1'b1);
    if (expect_pulse) exp_q.push_back(code);
    repeat (hold) @(negedge clk);
    set_key(code, 1'b0);
    repeat (gap) @(negedge clk);
  endtask

  task automatic press_clear(input logic [3:0] code);
    bit seen;
    seen = 1'b0;
    set_key(code, 1'b1);
    exp_q.push_back(code);
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (digitos_valid === 1'b1) seen = 1'b1;
    end
    check("clr_pulse_seen", 80'(seen), 80'(1));
    check("clr_code", 80'(digitos_value[3:0]), 80'(code));
    @(negedge clk);
    check("clr_empty", digitos_value, ALL_F);
    repeat (10) @(negedge clk);
    set_key(code, 1'b0);
    repeat (20) @(negedge clk);
  endtask

  // Per-cycle comparison against the packet model.
  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      if (rst || !teclado_en) begin
        check("off_col", 80'(col), 80'(3'b111));
        check("off_valid", 80'(digitos_valid), 80'(0));
        check("off_value", digitos_value, ALL_F);
        model_buf = ALL_F;
      end else begin
        check("col_one_low", 80'($countones(~col) <= 1), 80'(1));
        if (digitos_valid === 1'b1) begin
          n_pulses++;
          if (exp_q.size() == 0) begin
            check("stray_pulse", 80'(digitos_valid), 80'(0));
          end else begin
            chk_code = exp_q.pop_front();
            chk_exp  = {model_buf[75:0], chk_code};
            check("pulse_value", digitos_value, chk_exp);
            model_buf = (chk_code == 4'hA || chk_code == 4'hB) ? ALL_F : chk_exp;
          end
        end else if (allow_clear && digitos_value === ALL_F) begin
          model_buf = ALL_F;
        end else begin
          check("hold_value", digitos_value, model_buf);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [2:0] scan_exp [7];
  int         run;

  initial begin
    scan_exp = '{3'b110, 3'b110, 3'b101, 3'b101, 3'b011, 3'b011, 3'b110};
    rst = 1'b1;
    teclado_en = 1'b1;
    for (int r = 0; r < 4; r++) pressed[r] = 3'b000;
    model_buf = ALL_F;

    // Reset and scan rotation
    @(negedge clk);
    chk_on = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_col", 80'(col), 80'(3'b111));
      check("rst_value", digitos_value, ALL_F);
      check("rst_valid", 80'(digitos_valid), 80'(0));
    end
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("scan_col", 80'(col), 80'(scan_exp[i]));
    end

    // Press latency: key '1' held while re-enabling, pulse on the 8th cycle
    teclado_en = 1'b0;
    repeat (2) @(negedge clk);
    set_key(4'h1, 1'b1);
    exp_q.push_back(4'h1);
    teclado_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("latency_valid", 80'(digitos_valid), 80'(i == 8));
    end
    repeat (12) @(negedge clk);
    set_key(4'h1, 1'b0);
    repeat (20) @(negedge clk);

    // Digit entry
    for (int d = 2; d <= 5; d++) press(4'(d), 20, 20, 1'b1);
    check("entry_packet", digitos_value, 80'hFFFFFFFFFFFFFFF12345);
    check("entry_pending", 80'(exp_q.size()), 80'(0));

    // Clear keys
    press_clear(4'hB);
    press_clear(4'hA);

    // Bounce then long hold on '7'
    exp_q.push_back(4'h7);
    for (int i = 0; i < 10; i++) begin
      set_key(4'h7, (i % 2) == 0);
      repeat (2) @(negedge clk);
    end
    set_key(4'h7, 1'b1);
    repeat (200) @(negedge clk);
    set_key(4'h7, 1'b0);
    repeat (10) @(negedge clk);
    check("bounce_packet", digitos_value, {{19{4'hF}}, 4'h7});
    check("bounce_pending", 80'(exp_q.size()), 80'(0));

    // Two keys in the same column: rejected
    set_key(4'h2, 1'b1);
    set_key(4'h0, 1'b1);
    repeat (20) @(negedge clk);
    set_key(4'h2, 1'b0);
    set_key(4'h0, 1'b0);
    repeat (5) @(negedge clk);
    check("double_packet", digitos_value, {{19{4'hF}}, 4'h7});

    // Overflow: 21 keys 1..9,0,1..9,0,1
    for (int i = 0; i < 21; i++) press(((i % 10) == 9) ? 4'h0 : 4'((i % 10) + 1), 20, 20, 1'b1);
    check("overflow_packet", digitos_value, 80'h23456789012345678901);
    check("overflow_pending", 80'(exp_q.size()), 80'(0));

    // Timeout
    press(4'h9, 20, 0, 1'b1);
    allow_clear = 1'b1;
    repeat (50) @(negedge clk);
    check("timeout_not_early", 80'(digitos_value === ALL_F), 80'(0));
    repeat (30) @(negedge clk);
    check("timeout_clear", digitos_value, ALL_F);
    allow_clear = 1'b0;

    // Disable during debounce of '4'
    press(4'h5, 20, 20, 1'b1);
    set_key(4'h4, 1'b1);
    run = 0;
    for (int k = 0; k < 60 && run < 3; k++) begin
      @(negedge clk);
      run = (col == 3'b110) ? run + 1 : 0;
    end
    check("reached_debounce", 80'(run), 80'(3));
    teclado_en = 1'b0;
    repeat (10) @(negedge clk);
    check("disable_col", 80'(col), 80'(3'b111));
    check("disable_value", digitos_value, ALL_F);
    set_key(4'h4, 1'b0);
    repeat (2) @(negedge clk);
    teclado_en = 1'b1;
    repeat (40) @(negedge clk);
    check("disable_pending", 80'(exp_q.size()), 80'(0));
    check("total_pulses", 80'(n_pulses), 80'(31));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decodificador_teclado.md
# decodificador_teclado

Keypad front end for the door lock. Scans a 4x3 matrix keypad, debounces presses, maps each key to a 4-bit code and shifts it into a 20-digit packet. The packet goes to `operacional` on `digitos_value`, with a one-cycle `digitos_valid` pulse per accepted key. Gated by `operacional`'s `teclado_en`.

## Interface
- `SCAN_CYCLES`, default 10: cycles each column is driven before its rows are sampled.
- `DEBOUNCE_CYCLES`, default 100: consecutive stable cycles required to accept a press and to accept a release.
- `TIMEOUT_CYCLES`, default 5000: idle cycles after which a non-empty buffer is discarded.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `teclado_en` in 1: keypad enable from `operacional`.
- `lin` in 4: row inputs, active-low (pulled up).
- `col` out 3: column drives, active-low, at most one low at a time.
- `digitos_value` out `senhaPac_t`: `digits[19:0]`, 4 bits each. `digits[0]` is the newest key. 0xF means empty.
- `digitos_valid` out 1: one-cycle pulse when `digitos_value` has just been updated with a key.

## Operation
- Key map (row, col) → code:
  - r0 = 1, 2, 3
  - r1 = 4, 5, 6
  - r2 = 7, 8, 9
  - r3 = '*' (0xA), 0, '#' (0xB)
- FSM states: SCAN, DEBOUNCE, EMIT, CLEAR, RELEASE.
- SCAN:
  - `col` = ~(1 << idx).
  - After SCAN_CYCLES cycles, sample `lin`.
  - Exactly one row low: latch row/idx → DEBOUNCE.
  - No row low, or more than one row low: idx = (idx+1) mod 3, stay in SCAN.
- DEBOUNCE:
  - Column held.
  - Count cycles with `lin` equal to the latched pattern.
  - Any mismatch → SCAN, same idx, counters cleared.
  - Count reaches DEBOUNCE_CYCLES → EMIT.
- EMIT (1 cycle):
  - `digits` <= {digits[18:0], code}.
  - `digitos_valid` = 1.
  - Code 0xA or 0xB → CLEAR; else → RELEASE.
- CLEAR (1 cycle): `digits` <= all 0xF, `digitos_valid` = 0, → RELEASE.
- RELEASE:
  - Column held.
  - Needs DEBOUNCE_CYCLES consecutive cycles of `lin` = 4'b1111; any low row restarts the count.
  - Then → SCAN with idx+1.
- Buffer full (20 digits): the shift drops `digits[19]`. No error.
- Timeout:
  - Idle counter runs while in SCAN and the buffer is not all 0xF.
  - At TIMEOUT_CYCLES: `digits` <= all 0xF, no `digitos_valid`.
  - Counter cleared on EMIT and whenever the buffer is empty.
- `teclado_en` low, evaluated every cycle, highest priority after `rst`:
  - FSM → SCAN, idx = 0.
  - `col` = 3'b111.
  - All counters cleared.
  - `digits` = all 0xF, `digitos_valid` = 0.
  - A press in progress is dropped.

## Timing
- Reset values:
  - `col` = 3'b111.
  - `digitos_value` = all 1s.
  - `digitos_valid` = 0.
  - FSM in SCAN, idx = 0, counters 0.
- First cycle after `rst` falls with `teclado_en` = 1: `col` = 3'b110.
- Column rotation: each column is low for exactly SCAN_CYCLES cycles, in the order 110 → 101 → 011 → 110.
- All outputs are registered. `digitos_value` and `digitos_valid` change on the same edge.
- Press latency: `digitos_valid` rises DEBOUNCE_CYCLES+1 cycles after the SCAN sample that detected the key.
- After '*' or '#': the `digitos_valid` cycle shows the code in `digits[0]`; the following cycle shows all 0xF.
- One pulse per physical press, however long the key is held.
- Minimum spacing between two pulses: 2·DEBOUNCE_CYCLES + SCAN_CYCLES + 2.
- `rst` or `teclado_en` = 0 in the same cycle as EMIT: no pulse is output.

## Test plan
Bench keypad model: `lin[r]` = 0 iff the key at (r, c) is pressed and `col[c]` = 0. Parameters: SCAN_CYCLES = 2, DEBOUNCE_CYCLES = 4, TIMEOUT_CYCLES = 60.

- Reset and scan:
  - Stimulus: assert `rst` 5 cycles, then release with `teclado_en` = 1.
  - Response: during reset `col` = 111, `digitos_value` all F, `digitos_valid` = 0; after release `col` = 110, 110, 101, 101, 011, 011, 110.
- Digit entry:
  - Stimulus: press 1, 2, 3, 4, 5, each held 20 cycles with 20-cycle gaps.
  - Response: exactly 5 pulses; final `digits[4:0]` = 1, 2, 3, 4, 5 with `digits[0]` = 5; `digits[19:5]` = F.
- Clear and submit:
  - Stimulus: then press '#'.
  - Response: pulse with `digits[0]` = B, next cycle all F.
  - Stimulus: press '*'.
  - Response: pulse with `digits[0]` = A, next cycle all F.
- Bounce and hold:
  - Stimulus: press '7', toggling every 2 cycles for 20 cycles, then stable for 200 cycles.
  - Response: exactly one pulse, `digits[0]` = 7.
  - Stimulus: press '2' and '0' together (same column).
  - Response: no pulse.
- Overflow:
  - Stimulus: press 21 keys (1..9, 0, repeated).
  - Response: 21 pulses; `digits[19]` holds the 2nd key, `digits[0]` the 21st.
- Timeout and disable:
  - Stimulus: press '9', then idle 60 cycles.
  - Response: buffer all F, no pulse.
  - Stimulus: drop `teclado_en` during DEBOUNCE of '4'.
  - Response: no pulse, `col` = 111, buffer all F.
